cache_fill_fsm: RTL and testbench



---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_fill_fsm_if.sv | 33 +++
 rtl/cache_fill_fsm_word_counter.sv | 31 +++
 rtl/cache_fill_fsm.sv | 159 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss fill controller: geometry, state
// encoding and block address helpers.
package cache_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned WORDS       = 8;   // must be a power of 2
    localparam int unsigned WORD_BYTES  = 2;
    localparam int unsigned CNT_W       = $clog2(WORDS);
    localparam int unsigned OFFSET_BITS = $clog2(WORDS * WORD_BYTES);

    // Clears the byte-within-block bits of an address
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } fill_state_t;

    // Block-aligned base of a byte address
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & BLOCK_MASK;
    endfunction

    // Byte address of word idx within the block at base (wraps modulo 2^ADDR_W)
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the fill controller and its cache/memory environment.
//   master: the fill controller (consumes miss/memory returns, drives
//           memory requests, array writes and the stall)
//   slave : the cache pipeline / memory / array side
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                memory_data_valid;
    logic [DATA_W-1:0]   memory_data;
    logic                fsm_busy;
    logic                memory_en;
    logic [ADDR_W-1:0]   memory_address;
    logic                write_data_array;
    logic                write_tag_array;
    logic [CNT_W-1:0]    data_word_offset;
    logic [DATA_W-1:0]   data_out;
    logic                fill_done;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, memory_en, memory_address, write_data_array,
               write_tag_array, data_word_offset, data_out, fill_done
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, memory_en, memory_address, write_data_array,
               write_tag_array, data_word_offset, data_out, fill_done
    );

endinterface

// File: rtl/cache_fill_fsm_word_counter.sv
// Word index counter: W-bit register with synchronous clear, increment
// enable and a terminal-count flag; wraps naturally.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment enable
//   count    : current value
//   tc_c     : count is at its all-ones terminal value (combinational)
module word_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == {W{1'b1}});

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller. On a miss it issues WORDS back-to-back reads
// for the missing block, writes each returned word to the data array, writes
// the tag with the last word and stalls the pipeline until the fill is done.
// Ports: clk, rst (async active-high) and the master side of
// cache_fill_fsm_if (miss in, memory request/return, array writes, stall,
// fill_done).
// Optional FILL_PERF_CNT_EN adds saturating 16-bit fill_count (completed
// fills) and fill_cycles (cycles with fsm_busy high) outputs.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master bus
`ifdef FILL_PERF_CNT_EN
    ,
    output logic [15:0]      fill_count,
    output logic [15:0]      fill_cycles
`endif
);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic              base_load;

    logic              cnt_clr;
    logic              issue_inc, issue_tc;
    logic [CNT_W-1:0]  issue_cnt;
    logic              ret_inc, ret_tc;
    logic [CNT_W-1:0]  ret_cnt;

    logic              busy_c, mem_en_c, wr_data_c, wr_tag_c, done_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [CNT_W-1:0]  offset_c;

    // Request index within the block
    word_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (issue_inc),
        .count (issue_cnt),
        .tc_c  (issue_tc)
    );

    // Returned word index within the block
    word_counter #(.W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (ret_inc),
        .count (ret_cnt),
        .tc_c  (ret_tc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Block base latched only when a miss is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
        end else if (base_load) begin
            base_q <= block_base(bus.miss_address);
        end
    end

    // Next state and outputs
    always_comb begin
        state_d    = state_q;
        base_load  = 1'b0;
        cnt_clr    = 1'b0;
        issue_inc  = 1'b0;
        ret_inc    = 1'b0;
        busy_c     = 1'b0;
        mem_en_c   = 1'b0;
        mem_addr_c = '0;
        wr_data_c  = 1'b0;
        wr_tag_c   = 1'b0;
        offset_c   = '0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                // Stall in the miss cycle itself
                busy_c = bus.miss_detected;
                if (bus.miss_detected) begin
                    base_load = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                busy_c     = 1'b1;
                mem_en_c   = 1'b1;
                mem_addr_c = word_addr(base_q, issue_cnt);
                issue_inc  = 1'b1;
                if (issue_tc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returns are accepted while the fill is outstanding; the last one
        // finishes the fill even if requests are still being issued.
        if ((state_q == FILL || state_q == DRAIN) && bus.memory_data_valid) begin
            wr_data_c = 1'b1;
            offset_c  = ret_cnt;
            ret_inc   = 1'b1;
            if (ret_tc) begin
                wr_tag_c = 1'b1;
                state_d  = DONE;
            end
        end
    end

    assign bus.fsm_busy         = busy_c;
    assign bus.memory_en        = mem_en_c;
    assign bus.memory_address   = mem_addr_c;
    assign bus.write_data_array = wr_data_c;
    assign bus.write_tag_array  = wr_tag_c;
    assign bus.data_word_offset = offset_c;
    assign bus.data_out         = bus.memory_data;
    assign bus.fill_done        = done_c;

`ifdef FILL_PERF_CNT_EN
    // Saturating fill statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count  <= '0;
            fill_cycles <= '0;
        end else begin
            if (done_c && fill_count != 16'hFFFF) begin
                fill_count <= fill_count + 16'd1;
            end
            if (busy_c && fill_cycles != 16'hFFFF) begin
                fill_cycles <= fill_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory model.
// Each cycle: inputs driven 1 time unit after the rising edge, outputs
// sampled 2 units later and compared with hand-derived expected values.
module tb_cache_fill_fsm;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    // Per-fill request history for the memory model, indexed by cycle
    logic        req_en   [0:63];
    logic [15:0] req_addr [0:63];

    cache_fill_fsm_if bus ();

`ifdef FILL_PERF_CNT_EN
    logic [15:0] fill_count;
    logic [15:0] fill_cycles;
`endif

    cache_fill_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master)
`ifdef FILL_PERF_CNT_EN
        ,
        .fill_count  (fill_count),
        .fill_cycles (fill_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs expected whenever no fill is in progress and no miss is present
    task automatic check_quiet(input string tag);
        check_eq({tag, " busy"},  32'(bus.fsm_busy), 32'd0);
        check_eq({tag, " en"},    32'(bus.memory_en), 32'd0);
        check_eq({tag, " addr"},  32'(bus.memory_address), 32'd0);
        check_eq({tag, " wr"},    32'(bus.write_data_array), 32'd0);
        check_eq({tag, " tag"},   32'(bus.write_tag_array), 32'd0);
        check_eq({tag, " off"},   32'(bus.data_word_offset), 32'd0);
        check_eq({tag, " done"},  32'(bus.fill_done), 32'd0);
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.miss_detected     = 1'b0;
            bus.miss_address      = 16'h0;
            bus.memory_data_valid = stray;
            bus.memory_data       = 16'hDEAD;
            #2;
            check_quiet($sformatf("idle%0d", i));
        end
    endtask

    // One complete fill: cycle 0 is the miss cycle, the task returns after
    // sampling the fill_done cycle so a following call is back-to-back.
    task automatic run_fill(input int lat, input logic [15:0] addr, input bit hold_miss);
        logic [15:0] base;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        bit          exp_en, exp_wr;
        int          last;
        base = addr & 16'hFFF0;
        last = 9 + lat;
        for (int i = 0; i < 64; i++) begin
            req_en[i]   = 1'b0;
            req_addr[i] = 16'h0;
        end
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.miss_detected = 1'b1;
                bus.miss_address  = addr;
            end else if (hold_miss) begin
                bus.miss_detected = 1'b1;
                bus.miss_address  = (c >= 3) ? 16'h8000 : addr;
            end else begin
                bus.miss_detected = 1'b0;
                bus.miss_address  = 16'h0;
            end
            if (c >= lat && req_en[c-lat]) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = req_addr[c-lat] ^ 16'hA5A5;
            end else begin
                bus.memory_data_valid = 1'b0;
                bus.memory_data       = 16'hBEEF;
            end
            #2;
            req_en[c]   = bus.memory_en;
            req_addr[c] = bus.memory_address;

            exp_en   = (c >= 1 && c <= 8);
            exp_addr = exp_en ? 16'(int'(base) + 2 * (c - 1)) : 16'h0;
            exp_wr   = (c >= 1 + lat && c <= 8 + lat);
            check_eq($sformatf("L%0d c%0d busy", lat, c), 32'(bus.fsm_busy), 32'(c <= 8 + lat));
            check_eq($sformatf("L%0d c%0d en", lat, c), 32'(bus.memory_en), 32'(exp_en));
            check_eq($sformatf("L%0d c%0d addr", lat, c), 32'(bus.memory_address), 32'(exp_addr));
            check_eq($sformatf("L%0d c%0d wr", lat, c), 32'(bus.write_data_array), 32'(exp_wr));
            check_eq($sformatf("L%0d c%0d off", lat, c), 32'(bus.data_word_offset),
                     exp_wr ? 32'(c - 1 - lat) : 32'd0);
            check_eq($sformatf("L%0d c%0d tag", lat, c), 32'(bus.write_tag_array), 32'(c == 8 + lat));
            check_eq($sformatf("L%0d c%0d done", lat, c), 32'(bus.fill_done), 32'(c == last));
            if (exp_wr) begin
                exp_data = 16'(int'(base) + 2 * (c - 1 - lat)) ^ 16'hA5A5;
                check_eq($sformatf("L%0d c%0d data", lat, c), 32'(bus.data_out), 32'(exp_data));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = 16'h0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;

        // Reset state: stall still follows miss_detected
        @(posedge clk); #1;
        bus.miss_detected = 1'b1;
        #2;
        check_eq("rst busy_follows_miss", 32'(bus.fsm_busy), 32'd1);
        check_eq("rst en", 32'(bus.memory_en), 32'd0);
        bus.miss_detected = 1'b0;
        #1;
        check_quiet("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check_quiet("post_rst");

        // Two back-to-back fills, 4-cycle memory
        run_fill(4, 16'h1236, 1'b0);
        run_fill(4, 16'h4A5F, 1'b0);
        idle_cycles(1, 1'b0);
`ifdef FILL_PERF_CNT_EN
        check_eq("perf fill_count", 32'(fill_count), 32'd2);
        check_eq("perf fill_cycles", 32'(fill_cycles), 32'd26);
`endif

        // Returns overlapping issue
        run_fill(1, 16'h1236, 1'b0);
        idle_cycles(1, 1'b0);

        // Miss held high with a new address mid-fill
        run_fill(4, 16'h1236, 1'b1);

        // Stray returns in IDLE, then a fill near the top of the address space
        idle_cycles(2, 1'b1);
        run_fill(2, 16'hFFF2, 1'b0);
        idle_cycles(1, 1'b0);

        // Reset in cycle 6 of a fill
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.miss_detected     = (c == 0);
            bus.miss_address      = 16'h2000;
            bus.memory_data_valid = (c >= 5);
            bus.memory_data       = 16'h1111;
        end
        @(posedge clk); #1;
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b1;
        #2;
        check_quiet("midrst");
        @(posedge clk); #1;
        rst                   = 1'b0;
        bus.memory_data_valid = 1'b0;
        #2;
        check_quiet("midrst_rel");
        idle_cycles(3, 1'b1);
        run_fill(4, 16'h1236, 1'b0);
        idle_cycles(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
